// File: rtl/clk_rst_sequencer.sv
// Power-up / lock-loss reset sequencer on the free-running board clock.
// Brings up the PLL, then releases DDR and framebuffer resets in order; retries or faults on timeouts.
module clk_rst_sequencer #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned CALIB_TIMEOUT      = 1000000,
    parameter int unsigned FB_DELAY           = 16,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned CNT_W              = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       ddr_calib_done,
    output logic       pll_rst,
    output logic       ddr_rst_n,
    output logic       fb_rst_n,
    output logic       sys_ready,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [CNT_W-1:0]   PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CAL_LAST    = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   FB_LAST     = CNT_W'(FB_DELAY - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_RST_PLL   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_DDR_WAIT  = 3'd3,
        S_FB_DLY    = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [1:0]         fault_code_q, fault_code_d;
    logic [7:0]         loss_cnt_q, loss_cnt_d;
    logic [1:0]         lock_sync_q, cal_sync_q;
    logic               pll_rst_q, ddr_rst_n_q, fb_rst_n_q, sys_ready_q, fault_q;
    logic               lock_s, cal_s;

    assign lock_s = lock_sync_q[1];
    assign cal_s  = cal_sync_q[1];

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + CNT_W'(1);
        retry_d      = retry_q;
        fault_code_d = fault_code_q;
        loss_cnt_d   = loss_cnt_q;

        case (state_q)
            S_RST_PLL: begin
                if (timer_q == PLL_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (timer_q == LOCK_LAST) begin
                    if (retry_q == RETRY_LAST) begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'd1;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_RST_PLL;
                    end
                end
            end
            S_STABLE: begin
                // A glitch restarts the lock wait without counting as a retry.
                if (!lock_s)                     state_d = S_WAIT_LOCK;
                else if (timer_q == STABLE_LAST) state_d = S_DDR_WAIT;
            end
            S_DDR_WAIT: begin
                if (lock_s) begin
                    if (cal_s) begin
                        state_d = S_FB_DLY;
                    end else if (timer_q == CAL_LAST) begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'd2;
                    end
                end
            end
            S_FB_DLY: begin
                if (lock_s && timer_q == FB_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN:   ;
            S_FAULT: ;
            default: state_d = S_FAULT;
        endcase

        // Lock loss downstream of the lock phases overrides every other event.
        if (!lock_s && (state_q == S_DDR_WAIT || state_q == S_FB_DLY || state_q == S_RUN)) begin
            state_d = S_RST_PLL;
            if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end

        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RST_PLL;
            timer_q      <= '0;
            retry_q      <= '0;
            fault_code_q <= 2'd0;
            loss_cnt_q   <= 8'd0;
            lock_sync_q  <= 2'b00;
            cal_sync_q   <= 2'b00;
            pll_rst_q    <= 1'b1;
            ddr_rst_n_q  <= 1'b0;
            fb_rst_n_q   <= 1'b0;
            sys_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            fault_code_q <= fault_code_d;
            loss_cnt_q   <= loss_cnt_d;
            lock_sync_q  <= {lock_sync_q[0], pll_locked};
            cal_sync_q   <= {cal_sync_q[0], ddr_calib_done};
            // Outputs decode the state being entered so they change on the transition edge.
            pll_rst_q    <= (state_d == S_RST_PLL) || (state_d == S_FAULT);
            ddr_rst_n_q  <= (state_d == S_DDR_WAIT) || (state_d == S_FB_DLY) || (state_d == S_RUN);
            fb_rst_n_q   <= (state_d == S_RUN);
            sys_ready_q  <= (state_d == S_RUN);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign ddr_rst_n     = ddr_rst_n_q;
    assign fb_rst_n      = fb_rst_n_q;
    assign sys_ready     = sys_ready_q;
    assign fault         = fault_q;
    assign fault_code    = fault_code_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: expected output timelines are derived from event edges with plain arithmetic.
// Edge k is the k-th rising edge after the last edge that sampled rst_n low (k = 0).
module tb_clk_rst_sequencer;

    localparam int P = 4;   // PLL reset cycles
    localparam int T = 32;  // lock timeout
    localparam int S = 8;   // lock stable cycles
    localparam int C = 64;  // calibration timeout
    localparam int F = 4;   // framebuffer delay
    localparam int R = 2;   // max retries
    localparam int SYNC = 3; // input change after edge e is acted on at edge e+SYNC

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       ddr_calib_done = 1'b0;
    logic       pll_rst, ddr_rst_n, fb_rst_n, sys_ready, fault;
    logic [1:0] fault_code;
    logic [7:0] lock_loss_cnt;
    logic [4:0] obs;

    int checks = 0;
    int fails  = 0;

    clk_rst_sequencer #(
        .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T), .LOCK_STABLE_CYCLES(S),
        .CALIB_TIMEOUT(C), .FB_DELAY(F), .MAX_RETRIES(R), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .ddr_calib_done(ddr_calib_done),
        .pll_rst(pll_rst), .ddr_rst_n(ddr_rst_n), .fb_rst_n(fb_rst_n), .sys_ready(sys_ready),
        .fault(fault), .fault_code(fault_code), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {pll_rst, ddr_rst_n, fb_rst_n, sys_ready, fault};

    initial begin
        #2ms;
        $display("FAIL watchdog expired got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge k = 0 with rst_n about to be released.
    task automatic do_reset(input logic lock, input logic cal);
        pll_locked     = lock;
        ddr_calib_done = cal;
        rst_n          = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        checks++;
        if (obs !== 5'b10000) begin
            fails++;
            $display("FAIL reset_outputs got=%b required=%b", obs, 5'b10000);
        end
        checks++;
        if (fault_code !== 2'd0 || lock_loss_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_counters got=%0d/%0d required=0/0", fault_code, lock_loss_cnt);
        end
    endtask

    task automatic test_nominal();
        int lock_edge, ddr_edge, run_edge;
        logic [4:0] exp;
        do_reset(1'b0, 1'b0);
        lock_edge = 10 + int'($urandom_range(0, 8));
        ddr_edge  = lock_edge + SYNC + S;
        run_edge  = ddr_edge + 20 + SYNC + F;
        for (int k = 1; k <= run_edge + 8; k++) begin
            tick();
            exp = {k < P, k >= ddr_edge, k >= run_edge, k >= run_edge, 1'b0};
            checks++;
            if (obs !== exp || fault_code !== 2'd0) begin
                fails++;
                $display("FAIL nominal k=%0d got=%b/%0d required=%b/0", k, obs, fault_code, exp);
            end
            if (k == lock_edge) pll_locked = 1'b1;
            if (k == ddr_edge + 20) ddr_calib_done = 1'b1;
        end
        ddr_calib_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (obs !== 5'b01110) begin
                fails++;
                $display("FAIL cal_drop_in_run k=%0d got=%b required=%b", k, obs, 5'b01110);
            end
        end
    endtask

    task automatic test_stable_glitch();
        int drop_edge, back_edge, ddr_edge;
        logic [4:0] exp;
        do_reset(1'b0, 1'b0);
        drop_edge = 13 + int'($urandom_range(0, 4));
        back_edge = drop_edge + 3;
        ddr_edge  = back_edge + SYNC + S;
        for (int k = 1; k <= ddr_edge + 4; k++) begin
            tick();
            exp = {k < P, k >= ddr_edge, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp || lock_loss_cnt !== 8'd0) begin
                fails++;
                $display("FAIL stable_glitch k=%0d got=%b/%0d required=%b/0", k, obs, lock_loss_cnt, exp);
            end
            if (k == 10) pll_locked = 1'b1;
            if (k == drop_edge) pll_locked = 1'b0;
            if (k == back_edge) pll_locked = 1'b1;
        end
    endtask

    task automatic test_lock_timeout();
        logic [4:0] exp;
        logic [1:0] exp_code;
        int fault_edge;
        do_reset(1'b0, 1'b0);
        fault_edge = R * (P + T);
        for (int k = 1; k <= fault_edge + 10; k++) begin
            tick();
            exp = {(k < P) || (k >= P + T && k < 2 * P + T) || (k >= fault_edge),
                   1'b0, 1'b0, 1'b0, k >= fault_edge};
            exp_code = (k >= fault_edge) ? 2'd1 : 2'd0;
            checks++;
            if (obs !== exp || fault_code !== exp_code) begin
                fails++;
                $display("FAIL lock_timeout k=%0d got=%b/%0d required=%b/%0d", k, obs, fault_code, exp, exp_code);
            end
        end
        do_reset(1'b0, 1'b0);
        checks++;
        if (obs !== 5'b10000 || fault_code !== 2'd0) begin
            fails++;
            $display("FAIL fault_clear got=%b/%0d required=10000/0", obs, fault_code);
        end
    endtask

    task automatic test_calib_timeout();
        int ddr_edge, fault_edge;
        logic [4:0] exp;
        logic [1:0] exp_code;
        do_reset(1'b1, 1'b0);
        ddr_edge   = P + 1 + S;
        fault_edge = ddr_edge + C;
        for (int k = 1; k <= fault_edge + 10; k++) begin
            tick();
            exp = {(k < P) || (k >= fault_edge), (k >= ddr_edge) && (k < fault_edge),
                   1'b0, 1'b0, k >= fault_edge};
            exp_code = (k >= fault_edge) ? 2'd2 : 2'd0;
            checks++;
            if (obs !== exp || fault_code !== exp_code) begin
                fails++;
                $display("FAIL calib_timeout k=%0d got=%b/%0d required=%b/%0d", k, obs, fault_code, exp, exp_code);
            end
        end
    endtask

    task automatic test_lock_loss_repeat();
        int run_edge, exp_cnt;
        logic [4:0] exp;
        do_reset(1'b1, 1'b1);
        run_edge = P + 1 + S + 1 + F;
        repeat (run_edge) tick();
        checks++;
        if (sys_ready !== 1'b1) begin
            fails++;
            $display("FAIL initial_run got=%b required=1", sys_ready);
        end
        for (int it = 0; it < 300; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            pll_locked = 1'b0;
            for (int j = 1; j <= SYNC + P + 1 + S + 1 + F; j++) begin
                tick();
                exp = {(j >= SYNC) && (j < SYNC + P),
                       (j < SYNC) || (j >= SYNC + P + 1 + S),
                       (j < SYNC) || (j >= SYNC + P + 1 + S + 1 + F),
                       (j < SYNC) || (j >= SYNC + P + 1 + S + 1 + F),
                       1'b0};
                exp_cnt = (j < SYNC) ? it : it + 1;
                if (exp_cnt > 255) exp_cnt = 255;
                checks++;
                if (obs !== exp || lock_loss_cnt !== 8'(exp_cnt)) begin
                    fails++;
                    $display("FAIL lock_loss it=%0d j=%0d got=%b/%0d required=%b/%0d",
                             it, j, obs, lock_loss_cnt, exp, exp_cnt);
                end
                if (j == SYNC) pll_locked = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs !== 5'b10000 || lock_loss_cnt !== 8'd0 || fault_code !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid got=%b/%0d/%0d required=10000/0/0", obs, lock_loss_cnt, fault_code);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        int wait_cycles;
        logic [4:0] exp;
        do_reset(1'b1, 1'b0);
        wait_cycles = P + 1 + S + int'($urandom_range(1, 20));
        repeat (wait_cycles) tick();
        pll_locked     = 1'b0;
        ddr_calib_done = 1'b1;
        for (int j = 1; j <= SYNC + P + 3; j++) begin
            tick();
            exp = {(j >= SYNC) && (j < SYNC + P), j < SYNC, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp || lock_loss_cnt !== ((j < SYNC) ? 8'd0 : 8'd1)) begin
                fails++;
                $display("FAIL simultaneous j=%0d got=%b/%0d required=%b/%0d",
                         j, obs, lock_loss_cnt, exp, (j < SYNC) ? 0 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stable_glitch();
        test_lock_timeout();
        test_calib_timeout();
        test_lock_loss_repeat();
        test_reset_mid();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
